lc3_sequencer: RTL
==================

# lc3_sequencer

Parametrised successor to the LC-3 stage decoder: owns the instruction-stage state machine and the instruction register rather than taking a free-running external stage count. It adds a memory ready handshake with bounded wait, variable-length instruction sequencing (writeback skipped where unused), HALT on TRAP x25, sticky fault on memory timeout and a retired-instruction counter. It sits between the memory port and the datapath, and drives the same mux and latch-enable controls the datapath already consumes.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive not-ready cycles in FETCH or MEMORY before FAULT; 0 disables the timeout.
- TO_W, 4: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.
- CNT_W, 16: width of the RETIRED counter.
- HALT_VECT, 8'h25: TRAP vector that halts the sequencer.
- CLK  in  1  single clock; everything registers on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- MEM_DATA  in  16  instruction word from memory, captured into IR.
- MEM_READY  in  1  memory completes the current request this cycle.
- STAGE  out  3  state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5, FAULT=6.
- IR  out  16  registered instruction.
- ALU_CONTROL  out  3  ALU op select.
- ALU_MuxA  out  1  ALU A select.
- ALU_MuxB  out  3  ALU B select.
- MAR_LE, MAR_CONTROL, MEM_REQ, MEM_WE, RD_LE, REG_CONTROL, PC_CONTROL, PC_LE, IR_LE  out  1 each  datapath enables (see Operation).
- INSTR_DONE  out  1  one-cycle pulse on the final cycle of each instruction.
- RETIRED  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- FAULT  out  1  sticky memory timeout flag.
- HALTED  out  1  high in the HALT state.

## Operation
- Reset values: STAGE=FETCH, IR=0, RETIRED=0, wait counter=0, FAULT=0, HALTED=0.
- All 1-bit enables and INSTR_DONE decode combinationally from STAGE and IR, except in FETCH (below). All are 0 in HALT, FAULT and during any cycle with RST high.
- FETCH
  - MEM_REQ=1, MAR_CONTROL=1 (MAR=PC).
  - If MEM_READY=1: IR_LE=1, IR<=MEM_DATA, next state DECODE.
  - FETCH enables are the only controls that do not depend on the registered IR.
- DECODE
  - For LDR (0110) and STR (0111): MAR_LE=1, MAR_CONTROL=0 (MAR=Y).
  - Always lasts exactly one cycle.
- EXECUTE
  - PC_LE=1.
  - PC_CONTROL=1 for BR(0000), JMP(1100), JSR(0100), TRAP(1111), RTI(1000); otherwise 0.
  - Next state:
    - LDR or STR: MEMORY.
    - ADD(0001), AND(0101), NOT(1001) or MUL(1101): WRITEBACK.
    - TRAP with IR[7:0]==HALT_VECT: HALT.
    - Anything else: FETCH, with INSTR_DONE=1.
- MEMORY
  - MEM_REQ=1, MAR_CONTROL=0.
  - MEM_WE=1 for STR, held for the whole wait.
  - On MEM_READY: STR goes to FETCH with INSTR_DONE=1; LDR goes to WRITEBACK.
- WRITEBACK
  - RD_LE=1.
  - REG_CONTROL=1 for LDR; 0 otherwise.
  - INSTR_DONE=1; next state FETCH.
- ALU decode (all stages):
  - ADD, LDR, STR: 000. AND: 001. NOT: 010.
  - MUL: 100 if IR[5]=1; otherwise {1,IR[4:3]}.
  - Other opcodes: 000.
- ALU_MuxA is always 1.
- ALU_MuxB:
  - ADD with IR[5]=1: 100.
  - LDR and STR: 101.
  - Otherwise: 000.
- RETIRED increments on every edge where INSTR_DONE=1. It also increments on entry to HALT, because the HALT TRAP retires.
- Timeout:
  - The wait counter clears on entering FETCH or MEMORY, and on any cycle with MEM_READY=1.
  - It increments each FETCH/MEMORY cycle with MEM_READY=0.
  - If it equals MEM_TIMEOUT while MEM_READY=0 (and MEM_TIMEOUT≠0), the next state is FAULT and FAULT<=1.
- HALT and FAULT are absorbing; only RST leaves them. IR holds its value in both.

## Timing
- With MEM_READY tied high, latency is:
  - ADD/AND/NOT/MUL: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - BR/JMP/JSR/RTI/other: 3 cycles.
  - Each not-ready cycle adds one cycle.
- MEM_READY is sampled only while MEM_REQ=1; it is ignored in other states.
- MEM_READY and the timeout threshold in the same cycle: ready wins, no fault.
- RST asserted mid-instruction (including during a MEMORY write): the next state is FETCH with all registers at reset values. MEM_WE drops in the same cycle RST is high.
- RETIRED at all-ones with INSTR_DONE wraps to 0. No flag is raised.

## Test plan
- RST, then MEM_READY=1 and MEM_DATA=0x12A3 (ADD R1,R2,#3) -> STAGE 0,1,2,4; IR=0x12A3; ALU_MuxB=100; RD_LE only in cycle 4; INSTR_DONE in cycle 4; RETIRED=1.
- LDR 0x6042, with MEM_READY low for 3 cycles in MEMORY -> MAR_LE in DECODE; MEMORY lasts 4 cycles; REG_CONTROL=1 in WRITEBACK; total 8 cycles.
- STR 0x7042 -> MEM_WE=1 only in MEMORY; RD_LE never asserts; 4 cycles.
- BR 0x0E01 -> PC_CONTROL=1 and PC_LE=1 in EXECUTE; no WRITEBACK; 3 cycles. Then TRAP 0xF025 -> HALTED=1, RETIRED=2, MEM_REQ stays 0 thereafter.
- MEM_TIMEOUT=15 with MEM_READY held 0 in FETCH -> FAULT=1 after the 16th FETCH cycle; STAGE=6; RST restores STAGE=0 and FAULT=0.
- CNT_W=2 with 4 ADDs -> RETIRED goes 1,2,3,0. Separately, RST asserted mid-MEMORY of an STR -> MEM_WE=0 immediately and STAGE=0 the next cycle.

Source files
------------

// File: rtl/lc3_sequencer_if.sv
// Bus between the LC-3 sequencer and its memory port / datapath.
// The master side is the sequencer; the slave side is memory plus datapath.
interface lc3_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      i_mem_data;
  logic             i_mem_ready;
  logic [2:0]       o_stage;
  logic [15:0]      o_ir;
  logic [2:0]       o_alu_control;
  logic             o_alu_mux_a;
  logic [2:0]       o_alu_mux_b;
  logic             o_mar_le;
  logic             o_mar_control;
  logic             o_mem_req;
  logic             o_mem_we;
  logic             o_rd_le;
  logic             o_reg_control;
  logic             o_pc_control;
  logic             o_pc_le;
  logic             o_ir_le;
  logic             o_instr_done;
  logic [CNT_W-1:0] o_retired;
  logic             o_fault;
  logic             o_halted;

  modport master (
    input  i_mem_data, i_mem_ready,
    output o_stage, o_ir, o_alu_control, o_alu_mux_a, o_alu_mux_b,
           o_mar_le, o_mar_control, o_mem_req, o_mem_we, o_rd_le,
           o_reg_control, o_pc_control, o_pc_le, o_ir_le, o_instr_done,
           o_retired, o_fault, o_halted
  );

  modport slave (
    output i_mem_data, i_mem_ready,
    input  o_stage, o_ir, o_alu_control, o_alu_mux_a, o_alu_mux_b,
           o_mar_le, o_mar_control, o_mem_req, o_mem_we, o_rd_le,
           o_reg_control, o_pc_control, o_pc_le, o_ir_le, o_instr_done,
           o_retired, o_fault, o_halted
  );
endinterface

// File: rtl/lc3_sequencer.sv
// LC-3 instruction-stage sequencer: owns IR and the stage FSM, handshakes with
// memory under a bounded wait, and decodes datapath controls from stage and IR.
module lc3_sequencer #(
  parameter int         MEM_TIMEOUT = 15,
  parameter int         TO_W        = 4,
  parameter int         CNT_W       = 16,
  parameter logic [7:0] HALT_VECT   = 8'h25
) (
  input logic            i_clk,
  input logic            i_rst,
  lc3_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } stage_t;

  stage_t           r_stage;
  logic [15:0]      r_ir;
  logic [TO_W-1:0]  r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             r_fault;
  logic             r_halted;

  logic [3:0] w_op;
  logic       w_is_br, w_is_add, w_is_jsr, w_is_and, w_is_ldr, w_is_str;
  logic       w_is_rti, w_is_not, w_is_jmp, w_is_mul, w_is_trap;
  logic       w_is_mem, w_is_alu_wb, w_pc_redirect, w_halt_trap;
  logic       w_timeout, w_retire;

  assign w_op      = r_ir[15:12];
  assign w_is_br   = (w_op == 4'b0000);
  assign w_is_add  = (w_op == 4'b0001);
  assign w_is_jsr  = (w_op == 4'b0100);
  assign w_is_and  = (w_op == 4'b0101);
  assign w_is_ldr  = (w_op == 4'b0110);
  assign w_is_str  = (w_op == 4'b0111);
  assign w_is_rti  = (w_op == 4'b1000);
  assign w_is_not  = (w_op == 4'b1001);
  assign w_is_jmp  = (w_op == 4'b1100);
  assign w_is_mul  = (w_op == 4'b1101);
  assign w_is_trap = (w_op == 4'b1111);

  assign w_is_mem      = w_is_ldr | w_is_str;
  assign w_is_alu_wb   = w_is_add | w_is_and | w_is_not | w_is_mul;
  assign w_pc_redirect = w_is_br | w_is_jmp | w_is_jsr | w_is_trap | w_is_rti;
  assign w_halt_trap   = w_is_trap && (r_ir[7:0] == HALT_VECT);

  // Ready in the threshold cycle wins, so the timeout only fires with ready low.
  assign w_timeout = (MEM_TIMEOUT != 0) && !bus.i_mem_ready &&
                     (r_wait == TO_W'(MEM_TIMEOUT));

  logic w_mar_le, w_mar_control, w_mem_req, w_mem_we, w_rd_le, w_reg_control;
  logic w_pc_control, w_pc_le, w_ir_le, w_instr_done;

  always_comb begin
    w_mar_le      = 1'b0;
    w_mar_control = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_rd_le       = 1'b0;
    w_reg_control = 1'b0;
    w_pc_control  = 1'b0;
    w_pc_le       = 1'b0;
    w_ir_le       = 1'b0;
    w_instr_done  = 1'b0;
    if (!i_rst) begin
      case (r_stage)
        S_FETCH: begin
          w_mem_req     = 1'b1;
          w_mar_control = 1'b1;
          w_ir_le       = bus.i_mem_ready;
        end
        S_DECODE: begin
          w_mar_le = w_is_mem;
        end
        S_EXECUTE: begin
          w_pc_le      = 1'b1;
          w_pc_control = w_pc_redirect;
          w_instr_done = !(w_is_mem || w_is_alu_wb || w_halt_trap);
        end
        S_MEMORY: begin
          w_mem_req    = 1'b1;
          w_mem_we     = w_is_str;
          w_instr_done = w_is_str && bus.i_mem_ready;
        end
        S_WRITEBACK: begin
          w_rd_le       = 1'b1;
          w_reg_control = w_is_ldr;
          w_instr_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [2:0] w_alu_control;
  logic [2:0] w_alu_mux_b;

  always_comb begin
    w_alu_control = 3'b000;
    if (w_is_and)
      w_alu_control = 3'b001;
    else if (w_is_not)
      w_alu_control = 3'b010;
    else if (w_is_mul)
      w_alu_control = r_ir[5] ? 3'b100 : {1'b1, r_ir[4:3]};

    w_alu_mux_b = 3'b000;
    if (w_is_add && r_ir[5])
      w_alu_mux_b = 3'b100;
    else if (w_is_mem)
      w_alu_mux_b = 3'b101;
  end

  // The halting TRAP retires on its way into HALT even without INSTR_DONE.
  assign w_retire = w_instr_done || ((r_stage == S_EXECUTE) && w_halt_trap);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage   <= S_FETCH;
      r_ir      <= 16'h0000;
      r_wait    <= '0;
      r_retired <= '0;
      r_fault   <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      if (w_retire)
        r_retired <= r_retired + 1'b1;

      case (r_stage)
        S_FETCH: begin
          if (bus.i_mem_ready) begin
            r_ir    <= bus.i_mem_data;
            r_wait  <= '0;
            r_stage <= S_DECODE;
          end else if (w_timeout) begin
            r_stage <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          r_stage <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_wait <= '0;
          if (w_is_mem)
            r_stage <= S_MEMORY;
          else if (w_is_alu_wb)
            r_stage <= S_WRITEBACK;
          else if (w_halt_trap) begin
            r_stage  <= S_HALT;
            r_halted <= 1'b1;
          end else
            r_stage <= S_FETCH;
        end
        S_MEMORY: begin
          if (bus.i_mem_ready) begin
            r_wait  <= '0;
            r_stage <= w_is_str ? S_FETCH : S_WRITEBACK;
          end else if (w_timeout) begin
            r_stage <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WRITEBACK: begin
          r_wait  <= '0;
          r_stage <= S_FETCH;
        end
        S_HALT, S_FAULT: ;
        default: begin
          r_wait  <= '0;
          r_stage <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.o_stage       = r_stage;
  assign bus.o_ir          = r_ir;
  assign bus.o_alu_control = w_alu_control;
  assign bus.o_alu_mux_a   = 1'b1;
  assign bus.o_alu_mux_b   = w_alu_mux_b;
  assign bus.o_mar_le      = w_mar_le;
  assign bus.o_mar_control = w_mar_control;
  assign bus.o_mem_req     = w_mem_req;
  assign bus.o_mem_we      = w_mem_we;
  assign bus.o_rd_le       = w_rd_le;
  assign bus.o_reg_control = w_reg_control;
  assign bus.o_pc_control  = w_pc_control;
  assign bus.o_pc_le       = w_pc_le;
  assign bus.o_ir_le       = w_ir_le;
  assign bus.o_instr_done  = w_instr_done;
  assign bus.o_retired     = r_retired;
  assign bus.o_fault       = r_fault;
  assign bus.o_halted      = r_halted;

endmodule
